axis_xform_pipe: RTL and testbench
==================================

Name: axis_xform_pipe

Overview:
Parametrised AXI-Stream in-line transform stage, successor to the single-beat `axi` processing block. It applies a per-packet transform to each beat: pass, byte-reverse, add constant (wrap or saturate), or XOR mask. A 2-entry registered skid buffer gives full throughput under backpressure. It also reports per-packet byte count and arithmetic overflow status. It sits between an upstream AXI-Stream source and a downstream sink.

Parameters:
- TDATA_WIDTH, 32: data width in bits; multiple of 8, minimum 8.
- CNT_W, 16: width of the packet byte counter.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  TDATA_WIDTH  input beat data.
- s_axis_tkeep  in  TDATA_WIDTH/8  input byte-valid mask.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  TDATA_WIDTH  output beat data.
- m_axis_tkeep  out  TDATA_WIDTH/8  output byte mask.
- m_axis_tlast  out  1  output last.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- mode  in  2  0 pass, 1 byte-reverse, 2 add constant, 3 XOR constant.
- constant_value  in  TDATA_WIDTH  operand for modes 2 and 3.
- sat_en  in  1  mode 2 only: 1 saturate, 0 wrap modulo 2^TDATA_WIDTH.
- pkt_done  out  1  one-cycle pulse after the tlast beat completes on the master side.
- pkt_bytes  out  CNT_W  bytes in the completed packet; valid while pkt_done=1.
- pkt_overflow  out  1  1 if any beat of the completed packet overflowed in mode 2; valid while pkt_done=1.

Behaviour:
- Reset (aresetn=0, async): s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, pkt_done=0, pkt_bytes=0, pkt_overflow=0. Both buffer entries are empty, packet FSM=IDLE, accumulators are cleared. s_axis_tready rises on the first aclk edge after deassertion.
- Input handshake is s_axis_tvalid & s_axis_tready. Output handshake is m_axis_tvalid & m_axis_tready.
- Buffer: output register plus one skid register. s_axis_tready = !skid_valid and is registered. Latency is 1 cycle from input accept to m_axis_tvalid when the buffer is empty. With m_axis_tready held at 1, one beat per cycle is sustained.
- With the output register full and m_axis_tready=0, an accepted beat goes to the skid register and s_axis_tready drops on the next cycle.
- When the output drains, the skid entry moves into the output register. Ordering is strictly preserved and no beat is dropped or duplicated.
- Packet FSM:
  - IDLE: on the first accepted beat, latch mode, constant_value and sat_en, then go to IN_PKT. A single-beat packet (tlast=1) stays in IDLE.
  - IN_PKT: apply the latched controls. Changes on mode, constant_value or sat_en are ignored until the tlast beat is accepted, then return to IDLE.
- Transform is applied at input-accept time; tkeep and tlast pass unchanged unless stated.
  - Mode 0: data unchanged.
  - Mode 1: byte i maps to byte N-1-i on both tdata and tkeep (N = TDATA_WIDTH/8).
  - Mode 2: sum = data + constant computed at TDATA_WIDTH+1 bits. Carry-out sets the beat overflow flag. If sat_en, the result is all-ones on carry; otherwise the low TDATA_WIDTH bits.
  - Mode 3: data XOR constant.
- Counters update on output handshakes:
  - byte_acc += popcount(m_axis_tkeep), saturating at 2^CNT_W-1.
  - ovf_acc |= overflow flag carried with the beat.
- On the output handshake with m_axis_tlast=1:
  - Next cycle, pkt_done=1 with pkt_bytes and pkt_overflow reflecting the full packet.
  - Accumulators clear for the next packet.
  - pkt_bytes and pkt_overflow hold their value until the next pkt_done.
- A simultaneous input accept and output drain in the same cycle keeps occupancy unchanged.
- Reset mid-packet: buffered beats are discarded, no pkt_done is emitted for that packet, and the FSM returns to IDLE.
- Zero-tkeep beats are forwarded and count 0 bytes.

Test Plan:
- Mode 0, 1-beat packet 32'h12345678, tkeep 4'hF, tlast=1, m_axis_tready=1 -> output 32'h12345678 one cycle after accept; pkt_done with pkt_bytes=4, pkt_overflow=0.
- Mode 1, 32'hAABBCCDD, tkeep 4'b0011 -> tdata 32'hDDCCBBAA, tkeep 4'b1100, pkt_bytes=2.
- Mode 2, constant 32'h00000020, input 32'hFFFFFFF0:
  - sat_en=0 -> 32'h00000010, pkt_overflow=1.
  - sat_en=1 -> 32'hFFFFFFFF, pkt_overflow=1.
  - Input 32'h12345678 + 5 -> 32'h1234567D, pkt_overflow=0.
- 3-beat packet in mode 3, constant 32'hFFFF0000; switch mode to 0 after beat 1 -> all 3 beats XORed (mode latched); next packet uses mode 0.
- Backpressure: m_axis_tready=0 for 4 cycles during a 4-beat stream -> s_axis_tready falls after 2 beats are held; all 4 beats appear in order, no loss; pkt_bytes=16.
- Reset asserted after beat 2 of a 4-beat packet -> m_axis_tvalid=0 immediately, no pkt_done. The next packet 32'hCAFEF00D passes cleanly with pkt_bytes=4.

Source files
------------

// File: rtl/axis_xform_pipe.sv
// rtl/axis_xform_pipe.sv - AXI-Stream per-packet transform stage with 2-entry skid buffer
// and per-packet byte/overflow reporting.
module axis_xform_pipe #(
   parameter int TDATA_WIDTH = 32,
   parameter int CNT_W       = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   input  logic [1:0]                 mode,
   input  logic [TDATA_WIDTH-1:0]     constant_value,
   input  logic                       sat_en,
   output logic                       pkt_done,
   output logic [CNT_W-1:0]           pkt_bytes,
   output logic                       pkt_overflow
);

   localparam int NB  = TDATA_WIDTH / 8;
   localparam int PCW = $clog2(NB + 1);

   typedef enum logic {IDLE, IN_PKT} pkt_state_t;

   pkt_state_t              state_q, state_d;
   logic [1:0]              lat_mode_q, lat_mode_d;
   logic [TDATA_WIDTH-1:0]  lat_const_q, lat_const_d;
   logic                    lat_sat_q, lat_sat_d;

   logic                    out_valid_q, out_valid_d;
   logic [TDATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic [NB-1:0]           out_keep_q, out_keep_d;
   logic                    out_last_q, out_last_d;
   logic                    out_ovf_q, out_ovf_d;

   logic                    skid_valid_q, skid_valid_d;
   logic [TDATA_WIDTH-1:0]  skid_data_q, skid_data_d;
   logic [NB-1:0]           skid_keep_q, skid_keep_d;
   logic                    skid_last_q, skid_last_d;
   logic                    skid_ovf_q, skid_ovf_d;

   logic                    in_ready_q, in_ready_d;
   logic [CNT_W-1:0]        byte_acc_q, byte_acc_d;
   logic                    ovf_acc_q, ovf_acc_d;
   logic                    pkt_done_q, pkt_done_d;
   logic [CNT_W-1:0]        pkt_bytes_q, pkt_bytes_d;
   logic                    pkt_ovf_q, pkt_ovf_d;

   logic                    in_hs, out_hs;
   logic [1:0]              eff_mode;
   logic [TDATA_WIDTH-1:0]  eff_const;
   logic                    eff_sat;
   logic [TDATA_WIDTH:0]    sum;
   logic [TDATA_WIDTH-1:0]  x_data;
   logic [NB-1:0]           x_keep;
   logic                    x_ovf;
   logic [CNT_W:0]          acc_sum;
   logic [CNT_W-1:0]        acc_next;

   function automatic logic [PCW-1:0] popcnt(input logic [NB-1:0] k);
      logic [PCW-1:0] c;
      c = '0;
      for (int i = 0; i < NB; i++) c = c + PCW'(k[i]);
      return c;
   endfunction

   assign in_hs  = s_axis_tvalid & in_ready_q;
   assign out_hs = out_valid_q & m_axis_tready;

   // The first beat of a packet uses the live controls; later beats use the latched copy.
   assign eff_mode  = (state_q == IDLE) ? mode           : lat_mode_q;
   assign eff_const = (state_q == IDLE) ? constant_value : lat_const_q;
   assign eff_sat   = (state_q == IDLE) ? sat_en         : lat_sat_q;
   assign sum       = {1'b0, s_axis_tdata} + {1'b0, eff_const};

   always_comb begin
      x_data = s_axis_tdata;
      x_keep = s_axis_tkeep;
      x_ovf  = 1'b0;
      case (eff_mode)
         2'd1: begin
            for (int i = 0; i < NB; i++) begin
               x_data[8*i +: 8] = s_axis_tdata[8*(NB-1-i) +: 8];
               x_keep[i]        = s_axis_tkeep[NB-1-i];
            end
         end
         2'd2: begin
            x_ovf  = sum[TDATA_WIDTH];
            x_data = (sum[TDATA_WIDTH] && eff_sat) ? '1 : sum[TDATA_WIDTH-1:0];
         end
         2'd3: x_data = s_axis_tdata ^ eff_const;
         default: x_data = s_axis_tdata;
      endcase
   end

   assign acc_sum  = {1'b0, byte_acc_q} + (CNT_W+1)'(popcnt(out_keep_q));
   assign acc_next = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];

   always_comb begin
      state_d      = state_q;
      lat_mode_d   = lat_mode_q;
      lat_const_d  = lat_const_q;
      lat_sat_d    = lat_sat_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_keep_d   = out_keep_q;
      out_last_d   = out_last_q;
      out_ovf_d    = out_ovf_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_keep_d  = skid_keep_q;
      skid_last_d  = skid_last_q;
      skid_ovf_d   = skid_ovf_q;
      byte_acc_d   = byte_acc_q;
      ovf_acc_d    = ovf_acc_q;
      pkt_done_d   = 1'b0;
      pkt_bytes_d  = pkt_bytes_q;
      pkt_ovf_d    = pkt_ovf_q;

      if (in_hs) begin
         if (state_q == IDLE) begin
            lat_mode_d  = mode;
            lat_const_d = constant_value;
            lat_sat_d   = sat_en;
            state_d     = s_axis_tlast ? IDLE : IN_PKT;
         end else if (s_axis_tlast) begin
            state_d = IDLE;
         end
      end

      // Input is only accepted while the skid is empty, so skid and input never compete.
      if (!out_valid_q || out_hs) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_keep_d   = skid_keep_q;
            out_last_d   = skid_last_q;
            out_ovf_d    = skid_ovf_q;
            skid_valid_d = 1'b0;
         end else if (in_hs) begin
            out_valid_d = 1'b1;
            out_data_d  = x_data;
            out_keep_d  = x_keep;
            out_last_d  = s_axis_tlast;
            out_ovf_d   = x_ovf;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_hs) begin
         skid_valid_d = 1'b1;
         skid_data_d  = x_data;
         skid_keep_d  = x_keep;
         skid_last_d  = s_axis_tlast;
         skid_ovf_d   = x_ovf;
      end
      in_ready_d = !skid_valid_d;

      if (out_hs) begin
         if (out_last_q) begin
            pkt_done_d  = 1'b1;
            pkt_bytes_d = acc_next;
            pkt_ovf_d   = ovf_acc_q | out_ovf_q;
            byte_acc_d  = '0;
            ovf_acc_d   = 1'b0;
         end else begin
            byte_acc_d = acc_next;
            ovf_acc_d  = ovf_acc_q | out_ovf_q;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         lat_mode_q   <= '0;
         lat_const_q  <= '0;
         lat_sat_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_keep_q   <= '0;
         out_last_q   <= 1'b0;
         out_ovf_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_keep_q  <= '0;
         skid_last_q  <= 1'b0;
         skid_ovf_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         byte_acc_q   <= '0;
         ovf_acc_q    <= 1'b0;
         pkt_done_q   <= 1'b0;
         pkt_bytes_q  <= '0;
         pkt_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_mode_q   <= lat_mode_d;
         lat_const_q  <= lat_const_d;
         lat_sat_q    <= lat_sat_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_keep_q   <= out_keep_d;
         out_last_q   <= out_last_d;
         out_ovf_q    <= out_ovf_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_keep_q  <= skid_keep_d;
         skid_last_q  <= skid_last_d;
         skid_ovf_q   <= skid_ovf_d;
         in_ready_q   <= in_ready_d;
         byte_acc_q   <= byte_acc_d;
         ovf_acc_q    <= ovf_acc_d;
         pkt_done_q   <= pkt_done_d;
         pkt_bytes_q  <= pkt_bytes_d;
         pkt_ovf_q    <= pkt_ovf_d;
      end
   end

   assign s_axis_tready = in_ready_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tkeep  = out_keep_q;
   assign m_axis_tlast  = out_last_q;
   assign pkt_done      = pkt_done_q;
   assign pkt_bytes     = pkt_bytes_q;
   assign pkt_overflow  = pkt_ovf_q;

endmodule

// File: tb/tb_axis_xform_pipe.sv
// tb/tb_axis_xform_pipe.sv - self-checking bench for axis_xform_pipe with a queue-based
// reference model and directed packets.
module tb_axis_xform_pipe;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        s_tlast, s_tvalid, s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tlast, m_tvalid, m_tready;
   logic [1:0]  mode;
   logic [31:0] cval;
   logic        sat_en;
   logic        pkt_done;
   logic [15:0] pkt_bytes;
   logic        pkt_ovf;

   axis_xform_pipe #(.TDATA_WIDTH(32), .CNT_W(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .mode(mode), .constant_value(cval), .sat_en(sat_en),
      .pkt_done(pkt_done), .pkt_bytes(pkt_bytes), .pkt_overflow(pkt_ovf)
   );

   always #5 aclk = ~aclk;

   typedef struct {logic [31:0] d; logic [3:0] k; logic l; logic o;} beat_t;
   typedef struct {int b; logic o;} pkt_t;

   beat_t exp_q[$];
   pkt_t  pkt_q[$];
   int    checks = 0;
   int    failures = 0;

   logic        m_in_pkt = 1'b0;
   logic [1:0]  m_mode;
   logic [31:0] m_const;
   logic        m_sat;
   int          exp_bytes = 0;
   logic        exp_ovf = 1'b0;

   logic [31:0] last_data;
   logic [3:0]  last_keep;
   int          last_bytes;
   logic        last_ovf;
   int          done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t xform(input logic [1:0] md, input logic [31:0] c, input logic st,
                                   input logic [31:0] d, input logic [3:0] k, input logic l);
      beat_t b;
      logic [32:0] s;
      b.d = d; b.k = k; b.l = l; b.o = 1'b0;
      case (md)
         2'd1: for (int i = 0; i < 4; i++) begin
                  b.d[8*i +: 8] = d[8*(3-i) +: 8];
                  b.k[i] = k[3-i];
               end
         2'd2: begin
                  s = {1'b0, d} + {1'b0, c};
                  b.o = s[32];
                  b.d = (s[32] && st) ? 32'hFFFF_FFFF : s[31:0];
               end
         2'd3: b.d = d ^ c;
         default: b.d = d;
      endcase
      return b;
   endfunction

   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
      n = 0;
      while (!s_tready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      if (!s_tready) begin
         chk("send_timeout", 64'(n), 64'd0);
         s_tvalid = 1'b0;
         return;
      end
      if (!m_in_pkt) begin
         m_mode = mode; m_const = cval; m_sat = sat_en;
      end
      m_in_pkt = !l;
      exp_q.push_back(xform(m_mode, m_const, m_sat, d, k, l));
      @(negedge aclk);
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || pkt_q.size() != 0) && n < 100) begin
         @(negedge aclk);
         n++;
      end
      @(negedge aclk);
      chk("drain_beats", 64'(exp_q.size()), 64'd0);
      chk("drain_pkts", 64'(pkt_q.size()), 64'd0);
   endtask

   initial begin
      forever begin
         @(negedge aclk);
         #1;
         if (aresetn) begin
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 64'(m_tdata), 64'hDEAD);
               end else begin
                  beat_t e;
                  e = exp_q.pop_front();
                  chk("beat_data", 64'(m_tdata), 64'(e.d));
                  chk("beat_keep", 64'(m_tkeep), 64'(e.k));
                  chk("beat_last", 64'(m_tlast), 64'(e.l));
                  last_data = m_tdata;
                  last_keep = m_tkeep;
                  exp_bytes = exp_bytes + $countones(e.k);
                  if (exp_bytes > 65535) exp_bytes = 65535;
                  exp_ovf = exp_ovf | e.o;
                  if (e.l) begin
                     pkt_t p;
                     p.b = exp_bytes; p.o = exp_ovf;
                     pkt_q.push_back(p);
                     exp_bytes = 0;
                     exp_ovf = 1'b0;
                  end
               end
            end
            if (pkt_done) begin
               if (pkt_q.size() == 0) begin
                  chk("spurious_pkt_done", 64'(pkt_done), 64'd0);
               end else begin
                  pkt_t p;
                  p = pkt_q.pop_front();
                  chk("pkt_bytes", 64'(pkt_bytes), 64'(p.b));
                  chk("pkt_overflow", 64'(pkt_ovf), 64'(p.o));
                  last_bytes = int'(pkt_bytes);
                  last_ovf = pkt_ovf;
                  done_cnt++;
               end
            end
         end
      end
   end

   initial begin
      int dc;
      aresetn = 1'b0; m_tready = 1'b1;
      s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
      mode = 2'd0; cval = '0; sat_en = 1'b0;
      #1;
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_m_tdata", {m_tdata, 27'd0, m_tkeep, m_tlast}, 64'd0);
      chk("rst_pkt", {pkt_done, pkt_ovf, pkt_bytes}, 64'd0);
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      #1 chk("rst_rel_tready_low", 64'(s_tready), 64'd0);
      @(negedge aclk);
      chk("tready_after_edge", 64'(s_tready), 64'd1);

      // mode 0, single beat
      send(32'h12345678, 4'hF, 1'b1);
      #1 chk("lat1_valid", 64'(m_tvalid), 64'd1);
      chk("lat1_data", 64'(m_tdata), 64'h12345678);
      drain();
      chk("m0_bytes", 64'(last_bytes), 64'd4);
      chk("m0_ovf", 64'(last_ovf), 64'd0);

      // mode 1 byte reverse
      mode = 2'd1;
      send(32'hAABBCCDD, 4'b0011, 1'b1);
      drain();
      chk("m1_data", 64'(last_data), 64'hDDCCBBAA);
      chk("m1_keep", 64'(last_keep), 64'hC);
      chk("m1_bytes", 64'(last_bytes), 64'd2);

      // mode 2 wrap, saturate, no overflow
      mode = 2'd2; cval = 32'h20; sat_en = 1'b0;
      send(32'hFFFFFFF0, 4'hF, 1'b1);
      drain();
      chk("m2_wrap_data", 64'(last_data), 64'h00000010);
      chk("m2_wrap_ovf", 64'(last_ovf), 64'd1);
      sat_en = 1'b1;
      send(32'hFFFFFFF0, 4'hF, 1'b1);
      drain();
      chk("m2_sat_data", 64'(last_data), 64'hFFFFFFFF);
      chk("m2_sat_ovf", 64'(last_ovf), 64'd1);
      cval = 32'd5; sat_en = 1'b0;
      send(32'h12345678, 4'hF, 1'b1);
      drain();
      chk("m2_plain_data", 64'(last_data), 64'h1234567D);
      chk("m2_plain_ovf", 64'(last_ovf), 64'd0);

      // mode 3 latched across a mid-packet mode change, zero-keep beat in the middle
      mode = 2'd3; cval = 32'hFFFF0000;
      send(32'h12345678, 4'hF, 1'b0);
      mode = 2'd0;
      send(32'h0F0F0F0F, 4'h0, 1'b0);
      send(32'h00000000, 4'hF, 1'b1);
      drain();
      chk("m3_last_data", 64'(last_data), 64'hFFFF0000);
      chk("m3_bytes", 64'(last_bytes), 64'd8);
      send(32'h00000000, 4'hF, 1'b1);
      drain();
      chk("m3_next_pass", 64'(last_data), 64'h00000000);

      // backpressure: 4 cycles of m_tready=0 during a 4-beat stream
      mode = 2'd0;
      m_tready = 1'b0;
      fork
         begin
            send(32'h11111111, 4'hF, 1'b0);
            send(32'h22222222, 4'hF, 1'b0);
            send(32'h33333333, 4'hF, 1'b0);
            send(32'h44444444, 4'hF, 1'b1);
         end
         begin
            repeat (2) @(negedge aclk);
            #1;
            chk("bp_tready_low", 64'(s_tready), 64'd0);
            chk("bp_out_held", {m_tvalid, m_tdata}, {1'b1, 32'h11111111});
            repeat (2) @(negedge aclk);
            m_tready = 1'b1;
         end
      join
      drain();
      chk("bp_last", 64'(last_data), 64'h44444444);
      chk("bp_bytes", 64'(last_bytes), 64'd16);

      // reset in the middle of a 4-beat packet
      m_tready = 1'b0;
      send(32'hA0A0A0A0, 4'hF, 1'b0);
      send(32'hB0B0B0B0, 4'hF, 1'b0);
      dc = done_cnt;
      #2;
      aresetn = 1'b0;
      exp_q.delete(); pkt_q.delete();
      m_in_pkt = 1'b0; exp_bytes = 0; exp_ovf = 1'b0;
      #1;
      chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
      chk("midrst_done", 64'(pkt_done), 64'd0);
      @(negedge aclk);
      aresetn = 1'b1; m_tready = 1'b1;
      @(negedge aclk);
      send(32'hCAFEF00D, 4'hF, 1'b1);
      drain();
      chk("post_rst_data", 64'(last_data), 64'hCAFEF00D);
      chk("post_rst_bytes", 64'(last_bytes), 64'd4);
      chk("post_rst_done_cnt", 64'(done_cnt - dc), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
